// File: rtl/bfu_array_if.sv
// Handshake and data bundle for the Kyber butterfly array.
// The slave modport belongs to the array and the master modport to the sequencer.
interface bfu_array_if #(
  parameter int LANES = 2,
  parameter int TAG_W = 8
);
  logic                  i_valid;
  logic                  o_ready;
  logic                  i_intt;
  logic [TAG_W-1:0]      i_tag;
  logic [16*LANES-1:0]   i_a;
  logic [16*LANES-1:0]   i_b;
  logic [16*LANES-1:0]   i_twiddle;
  logic                  o_valid;
  logic                  i_ready;
  logic [TAG_W-1:0]      o_tag;
  logic [16*LANES-1:0]   o_a;
  logic [16*LANES-1:0]   o_b;

  modport slave (
    input  i_valid, i_intt, i_tag, i_a, i_b, i_twiddle, i_ready,
    output o_ready, o_valid, o_tag, o_a, o_b
  );

  modport master (
    output i_valid, i_intt, i_tag, i_a, i_b, i_twiddle, i_ready,
    input  o_ready, o_valid, o_tag, o_a, o_b
  );
endinterface

// File: rtl/bfu_array.sv
// LANES-wide 4-stage Kyber butterfly array (CT for NTT, GS for INTT) with
// Montgomery reduction; a single global enable stalls the whole pipeline.
module bfu_array #(
  parameter int                 LANES = 2,
  parameter logic signed [15:0] Q     = 16'sd3329,
  parameter logic signed [15:0] QINV  = -16'sd3327,
  parameter int                 TAG_W = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  bfu_array_if.slave bus
);
  logic                  w_en;
  logic                  w_acc;
  logic [3:0]            r_vld;
  logic [2:0]            r_intt;
  logic [3:0][TAG_W-1:0] r_tag;

  // Bring a value from (-2Q,2Q) back into (-Q,Q) with one conditional correction.
  function automatic logic signed [15:0] fix(input logic signed [17:0] x);
    logic signed [17:0] q18;
    q18 = 18'(Q);
    if (x >= q18)
      return 16'(x - q18);
    else if (x <= -q18)
      return 16'(x + q18);
    return 16'(x);
  endfunction

  assign w_en        = ~r_vld[3] | bus.i_ready;
  assign w_acc       = bus.i_valid & w_en;
  assign bus.o_ready = w_en;
  assign bus.o_valid = r_vld[3];
  assign bus.o_tag   = r_tag[3];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld  <= '0;
      r_intt <= '0;
      r_tag  <= '0;
    end else if (w_en) begin
      r_vld  <= {r_vld[2:0], w_acc};
      r_intt <= {r_intt[1:0], bus.i_intt};
      r_tag  <= {r_tag[2:0], bus.i_tag};
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic signed [15:0] w_a, w_b, w_z;
    logic signed [16:0] w_s1_a, w_s1_b;
    logic signed [31:0] w_p;
    logic        [15:0] w_t;
    logic signed [47:0] w_d;
    logic signed [15:0] w_r;
    logic signed [16:0] r_s1_a, r_s1_b, r_s2_a, r_s3_a;
    logic signed [15:0] r_s1_z, r_s3_t, r_o_a, r_o_b;
    logic signed [31:0] r_s2_p, r_s3_p;

    assign w_a = bus.i_a[16*gi +: 16];
    assign w_b = bus.i_b[16*gi +: 16];
    assign w_z = bus.i_twiddle[16*gi +: 16];

    // GS does its add/sub before the multiply, so S1 already holds a+b and b-a.
    assign w_s1_a = bus.i_intt ? 17'(w_a) + 17'(w_b) : 17'(w_a);
    assign w_s1_b = bus.i_intt ? 17'(w_b) - 17'(w_a) : 17'(w_b);
    assign w_p    = 32'(r_s1_b) * 32'(r_s1_z);
    assign w_t    = r_s2_p[15:0] * QINV;
    // Low 16 bits of p - t*Q are zero by construction of t.
    assign w_d    = 48'(r_s3_p) - 48'(r_s3_t) * 48'(Q);
    assign w_r    = 16'(w_d >>> 16);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_s1_a <= '0;
        r_s1_b <= '0;
        r_s1_z <= '0;
        r_s2_a <= '0;
        r_s2_p <= '0;
        r_s3_a <= '0;
        r_s3_p <= '0;
        r_s3_t <= '0;
        r_o_a  <= '0;
        r_o_b  <= '0;
      end else if (w_en) begin
        r_s1_a <= w_s1_a;
        r_s1_b <= w_s1_b;
        r_s1_z <= w_z;
        r_s2_a <= r_s1_a;
        r_s2_p <= w_p;
        r_s3_a <= r_s2_a;
        r_s3_p <= r_s2_p;
        r_s3_t <= w_t;
        if (r_intt[2]) begin
          r_o_a <= fix(18'(r_s3_a));
          r_o_b <= w_r;
        end else begin
          r_o_a <= fix(18'(r_s3_a) + 18'(w_r));
          r_o_b <= fix(18'(r_s3_a) - 18'(w_r));
        end
      end
    end

    assign bus.o_a[16*gi +: 16] = r_o_a;
    assign bus.o_b[16*gi +: 16] = r_o_b;
  end
endmodule

// File: tb/tb_bfu_array.sv
// Self-checking bench for bfu_array: a reference model fills a scoreboard at
// input handshake, and a monitor pops and compares at output handshake.
`timescale 1ns/1ps
module tb_bfu_array;
  localparam int LANES = 2;
  localparam int TAG_W = 8;
  localparam int Q     = 3329;
  localparam int QINV  = -3327;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  bfu_array_if #(.LANES(LANES), .TAG_W(TAG_W)) bus ();

  bfu_array #(
    .LANES(LANES), .Q(16'sd3329), .QINV(-16'sd3327), .TAG_W(TAG_W)
  ) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [TAG_W-1:0]    tag;
    logic [16*LANES-1:0] a;
    logic [16*LANES-1:0] b;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   rx_count = 0;

  function automatic int mont_m(longint p);
    longint t;
    t = ((p & 64'hFFFF) * QINV) & 64'hFFFF;
    if (t > 32767) t = t - 65536;
    return int'((p - t * Q) / 65536);
  endfunction

  function automatic int fix_m(int x);
    if (x >= Q) return x - Q;
    if (x <= -Q) return x + Q;
    return x;
  endfunction

  function automatic exp_t model(input logic intt, input logic [TAG_W-1:0] tag,
                                 input logic [16*LANES-1:0] a, b, z);
    exp_t e;
    e.tag = tag;
    e.a   = '0;
    e.b   = '0;
    for (int l = 0; l < LANES; l++) begin
      int av, bv, zv, r, ra, rb;
      av = $signed(a[16*l +: 16]);
      bv = $signed(b[16*l +: 16]);
      zv = $signed(z[16*l +: 16]);
      if (intt) begin
        ra = fix_m(av + bv);
        rb = mont_m(longint'(bv - av) * zv);
      end else begin
        r  = mont_m(longint'(bv) * zv);
        ra = fix_m(av + r);
        rb = fix_m(av - r);
      end
      e.a[16*l +: 16] = 16'(ra);
      e.b[16*l +: 16] = 16'(rb);
    end
    return e;
  endfunction

  // Output monitor: one line per delivered transaction.
  always @(negedge i_clk) begin
    if (i_rst_n && bus.o_valid && bus.i_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_output: tag=%0d a=%h b=%h, required none", bus.o_tag, bus.o_a, bus.o_b);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        rx_count++;
        $display("out tag=%0d a=%h b=%h", bus.o_tag, bus.o_a, bus.o_b);
        if ({bus.o_tag, bus.o_a, bus.o_b} !== {e.tag, e.a, e.b}) begin
          n_errors++;
          $display("FAIL result: got tag=%0d a=%h b=%h, required tag=%0d a=%h b=%h",
                   bus.o_tag, bus.o_a, bus.o_b, e.tag, e.a, e.b);
        end
        for (int l = 0; l < LANES; l++) begin
          int oa, ob;
          oa = $signed(bus.o_a[16*l +: 16]);
          ob = $signed(bus.o_b[16*l +: 16]);
          n_checks++;
          if (oa <= -Q || oa >= Q || ob <= -Q || ob >= Q) begin
            n_errors++;
            $display("FAIL range lane%0d: got a=%0d b=%0d, required within (-%0d,%0d)", l, oa, ob, Q, Q);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic intt, input logic [TAG_W-1:0] tag,
                      input logic [16*LANES-1:0] a, b, z);
    bit done;
    done          = 1'b0;
    bus.i_valid   = 1'b1;
    bus.i_intt    = intt;
    bus.i_tag     = tag;
    bus.i_a       = a;
    bus.i_b       = b;
    bus.i_twiddle = z;
    for (int k = 0; k < 500 && !done; k++) begin
      @(negedge i_clk);
      if (bus.o_ready) begin
        exp_q.push_back(model(intt, tag, a, b, z));
        done = 1'b1;
      end
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: o_ready stayed 0, required 1 within 500 cycles");
    end
    @(posedge i_clk);
    #1;
    bus.i_valid = 1'b0;
  endtask

  function automatic logic [16*LANES-1:0] rnd_vec();
    logic [16*LANES-1:0] v;
    for (int l = 0; l < LANES; l++) begin
      int x;
      case ($urandom_range(7))
        0: x = Q - 1;
        1: x = -(Q - 1);
        default: x = int'($urandom_range(2*Q - 2)) - (Q - 1);
      endcase
      v[16*l +: 16] = 16'(x);
    end
    return v;
  endfunction

  task automatic test_reset();
    #12;
    n_checks++;
    if (bus.o_valid !== 1'b0) begin n_errors++; $display("FAIL reset_o_valid: got %b, required 0", bus.o_valid); end
    n_checks++;
    if (bus.o_tag !== '0) begin n_errors++; $display("FAIL reset_o_tag: got %h, required 0", bus.o_tag); end
    n_checks++;
    if (bus.o_a !== '0) begin n_errors++; $display("FAIL reset_o_a: got %h, required 0", bus.o_a); end
    n_checks++;
    if (bus.o_b !== '0) begin n_errors++; $display("FAIL reset_o_b: got %h, required 0", bus.o_b); end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    n_checks++;
    if (bus.o_ready !== 1'b1) begin n_errors++; $display("FAIL reset_o_ready: got %b, required 1", bus.o_ready); end
  endtask

  // Montgomery results are only guaranteed in (-Q,Q), so the hand-worked
  // values are compared modulo Q; the monitor checks the exact bits.
  task automatic test_directed();
    int t_intt[4] = '{0, 0, 1, 1};
    int t_a[4]    = '{100, 3000, 3000, 0};
    int t_b[4]    = '{200, 3000, 1000, 0};
    int t_ea[4]   = '{300, 2671, 671, 0};
    int t_eb[4]   = '{-100, 0, -2000, 0};
    for (int c = 0; c < 4; c++) begin
      int lat;
      lat = 0;
      send(1'(t_intt[c]), 8'(8'h10 + c), {LANES{16'(t_a[c])}}, {LANES{16'(t_b[c])}}, {LANES{16'(2285)}});
      for (int k = 1; k <= 20 && lat == 0; k++) begin
        @(negedge i_clk);
        if (bus.o_valid) lat = k;
      end
      n_checks++;
      if (lat != 4) begin n_errors++; $display("FAIL latency case%0d: got %0d, required 4", c, lat); end
      for (int l = 0; l < LANES; l++) begin
        int oa, ob;
        oa = $signed(bus.o_a[16*l +: 16]);
        ob = $signed(bus.o_b[16*l +: 16]);
        n_checks++;
        if ((oa - t_ea[c]) % Q != 0) begin
          n_errors++;
          $display("FAIL directed_a case%0d lane%0d: got %0d, required %0d mod Q", c, l, oa, t_ea[c]);
        end
        n_checks++;
        if ((ob - t_eb[c]) % Q != 0) begin
          n_errors++;
          $display("FAIL directed_b case%0d lane%0d: got %0d, required %0d mod Q", c, l, ob, t_eb[c]);
        end
      end
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic drain(input string name, input int rx_expected, input int rx_start);
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge i_clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL %s_drain: %0d outputs outstanding, required 0", name, exp_q.size());
    end
    n_checks++;
    if (rx_count - rx_start != rx_expected) begin
      n_errors++;
      $display("FAIL %s_count: got %0d outputs, required %0d", name, rx_count - rx_start, rx_expected);
    end
  endtask

  task automatic test_back_to_back();
    int rx0, n_stall;
    rx0     = rx_count;
    n_stall = 0;
    fork
      begin
        for (int i = 0; i < 16; i++)
          send(1'(i % 2), 8'(8'h40 + i), rnd_vec(), rnd_vec(), rnd_vec());
      end
      begin
        for (int c = 0; c < 40; c++) begin
          @(posedge i_clk);
          #1;
          bus.i_ready = !(c >= 6 && c <= 9);
        end
      end
      begin
        bit prev_stall;
        logic [TAG_W+32*LANES-1:0] snap;
        prev_stall = 1'b0;
        snap       = '0;
        for (int c = 0; c < 40; c++) begin
          @(negedge i_clk);
          if (prev_stall) begin
            n_checks++;
            if (!bus.o_valid || {bus.o_tag, bus.o_a, bus.o_b} !== snap) begin
              n_errors++;
              $display("FAIL stall_hold: got v=%b %h, required v=1 %h", bus.o_valid, {bus.o_tag, bus.o_a, bus.o_b}, snap);
            end
          end
          if (bus.o_valid && !bus.i_ready) begin
            n_stall++;
            n_checks++;
            if (bus.o_ready !== 1'b0) begin
              n_errors++;
              $display("FAIL stall_o_ready: got %b, required 0", bus.o_ready);
            end
            prev_stall = 1'b1;
            snap       = {bus.o_tag, bus.o_a, bus.o_b};
          end else begin
            prev_stall = 1'b0;
          end
        end
      end
    join
    bus.i_ready = 1'b1;
    n_checks++;
    if (n_stall < 4) begin n_errors++; $display("FAIL stall_seen: got %0d stalled cycles, required 4", n_stall); end
    drain("stream", 16, rx0);
  endtask

  task automatic test_reset_flight();
    int lat;
    bus.i_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(1'(i % 2), 8'(8'h80 + i), rnd_vec(), rnd_vec(), rnd_vec());
    @(posedge i_clk);
    #1;
    n_checks++;
    if (bus.o_valid !== 1'b1) begin n_errors++; $display("FAIL flight_pre_valid: got %b, required 1", bus.o_valid); end
    #2;
    i_rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.o_valid !== 1'b0 || bus.o_a !== '0 || bus.o_tag !== '0) begin
      n_errors++;
      $display("FAIL flight_reset: got v=%b tag=%h a=%h, required v=0 tag=0 a=0", bus.o_valid, bus.o_tag, bus.o_a);
    end
    exp_q.delete();
    bus.i_ready = 1'b1;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge i_clk);
      n_checks++;
      if (bus.o_valid !== 1'b0) begin n_errors++; $display("FAIL flight_idle cyc%0d: got o_valid=%b, required 0", k, bus.o_valid); end
    end
    @(posedge i_clk);
    #1;
    send(1'b0, 8'h99, rnd_vec(), rnd_vec(), rnd_vec());
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge i_clk);
      if (bus.o_valid) lat = k;
    end
    n_checks++;
    if (lat != 4) begin n_errors++; $display("FAIL flight_latency: got %0d, required 4", lat); end
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_random();
    int rx0;
    bit drv_done;
    rx0      = rx_count;
    drv_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++)
          send(1'($urandom_range(1)), 8'($urandom_range(255)), rnd_vec(), rnd_vec(), rnd_vec());
        drv_done = 1'b1;
      end
      begin
        for (int c = 0; c < 2000 && !drv_done; c++) begin
          @(posedge i_clk);
          #1;
          bus.i_ready = ($urandom_range(3) != 0);
        end
      end
    join
    bus.i_ready = 1'b1;
    drain("random", 40, rx0);
  endtask

  initial begin
    bus.i_valid   = 1'b0;
    bus.i_intt    = 1'b0;
    bus.i_tag     = '0;
    bus.i_a       = '0;
    bus.i_b       = '0;
    bus.i_twiddle = '0;
    bus.i_ready   = 1'b1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_flight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
